// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Purpose
//   Issues one floating-point operation at a time to an fpu that uses a
//   run/done handshake. A command arrives on a valid/ready port and is latched
//   onto the fpu operand/opcode lines. The block then waits for the fpu done
//   pulse, or gives up after TIMEOUT cycles. The fpu result and status flags are
//   returned on a valid/ready result port. Only one operation is in flight.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_a, cmd_b are the payload
//   res_valid/ready     result handshake; res_data, res_flags are the payload
//                       res_flags = {timeout, div_by_zero, underflow, overflow}
//   ops_cnt             completed operations (timeouts included), wraps
//   fpu_run/running     registered run strobes to the fpu
//   fpu_op/in0/in1      operation and operands, stable until the next accept
//   fpu_done            1-cycle completion pulse from the fpu
//   fpu_out0            fpu result, valid the cycle after fpu_done
//   fpu_ovf/unf/dbz     fpu status flags, sampled together with fpu_done
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 2,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPCODE_W-1:0] cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  // result port
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [3:0]          res_flags,
  output logic [CNT_W-1:0]    ops_cnt,
  // fpu interface
  output logic                fpu_run,
  output logic                fpu_running,
  output logic [OPCODE_W-1:0] fpu_op,
  output logic [DATA_W-1:0]   fpu_in0,
  output logic [DATA_W-1:0]   fpu_in1,
  input  logic                fpu_done,
  input  logic [DATA_W-1:0]   fpu_out0,
  input  logic                fpu_ovf,
  input  logic                fpu_unf,
  input  logic                fpu_dbz
);

  // The wait timer only has to reach TIMEOUT-1.
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_q,       state_d;
  logic [TMR_W-1:0]    timer_q,       timer_d;
  logic                cmd_ready_q,   cmd_ready_d;
  logic                res_valid_q,   res_valid_d;
  logic [DATA_W-1:0]   res_data_q,    res_data_d;
  logic [3:0]          res_flags_q,   res_flags_d;
  logic [CNT_W-1:0]    ops_cnt_q,     ops_cnt_d;
  logic                fpu_run_q,     fpu_run_d;
  logic                fpu_running_q, fpu_running_d;
  logic [OPCODE_W-1:0] fpu_op_q,      fpu_op_d;
  logic [DATA_W-1:0]   fpu_in0_q,     fpu_in0_d;
  logic [DATA_W-1:0]   fpu_in1_q,     fpu_in1_d;

  logic cmd_accept;
  logic res_accept;

  // cmd_ready_q is only high in IDLE, but the state check keeps acceptance
  // tied to the FSM even if the two ever drift apart.
  assign cmd_accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
  assign res_accept = (state_q == ST_RESP) && res_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    ops_cnt_d   = ops_cnt_q;
    fpu_op_d    = fpu_op_q;
    fpu_in0_d   = fpu_in0_q;
    fpu_in1_d   = fpu_in1_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          fpu_op_d  = cmd_op;
          fpu_in0_d = cmd_a;
          fpu_in1_d = cmd_b;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // done is checked first so a pulse on the final timer cycle still
        // yields a normal result.
        if (fpu_done) begin
          res_flags_d = {1'b0, fpu_dbz, fpu_unf, fpu_ovf};
          state_d     = ST_CAPT;
        end else if (timer_q == TMR_LAST) begin
          res_data_d  = '0;
          res_flags_d = 4'b1000;
          state_d     = ST_RESP;
        end
      end

      ST_CAPT: begin
        // fpu_out0 becomes valid one cycle after the done pulse.
        res_data_d = fpu_out0;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (res_accept) begin
          ops_cnt_d = ops_cnt_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and fpu strobes are decoded from the next state and then
  // registered, so every output changes cleanly on a clock edge.
  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    res_valid_d   = (state_d == ST_RESP);
    fpu_run_d     = (state_d == ST_WAIT);
    fpu_running_d = (state_d == ST_WAIT) || (state_d == ST_CAPT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      cmd_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      ops_cnt_q     <= '0;
      fpu_run_q     <= 1'b0;
      fpu_running_q <= 1'b0;
      fpu_op_q      <= '0;
      fpu_in0_q     <= '0;
      fpu_in1_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      ops_cnt_q     <= ops_cnt_d;
      fpu_run_q     <= fpu_run_d;
      fpu_running_q <= fpu_running_d;
      fpu_op_q      <= fpu_op_d;
      fpu_in0_q     <= fpu_in0_d;
      fpu_in1_q     <= fpu_in1_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;
  assign ops_cnt     = ops_cnt_q;
  assign fpu_run     = fpu_run_q;
  assign fpu_running = fpu_running_q;
  assign fpu_op      = fpu_op_q;
  assign fpu_in0     = fpu_in0_q;
  assign fpu_in1     = fpu_in1_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Drives fpu_issue_ctrl against a behavioural fpu. The fpu returns
// out0 = in0 + in1 and pulses done LAT cycles after run rises. Outside the
// cycle after done it drives 0xDEADBEEF on out0. Operations are listed in a
// table of records; reset and counter-wrap cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  localparam int DATA_W   = 32;
  localparam int OPCODE_W = 2;
  localparam int TIMEOUT  = 8;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [OPCODE_W-1:0] cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_data;
  logic [3:0]          res_flags;
  logic [CNT_W-1:0]    ops_cnt;
  logic                fpu_run;
  logic                fpu_running;
  logic [OPCODE_W-1:0] fpu_op;
  logic [DATA_W-1:0]   fpu_in0;
  logic [DATA_W-1:0]   fpu_in1;
  logic                fpu_done;
  logic [DATA_W-1:0]   fpu_out0;
  logic                fpu_ovf;
  logic                fpu_unf;
  logic                fpu_dbz;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DATA_W  (DATA_W),
    .OPCODE_W(OPCODE_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .ops_cnt    (ops_cnt),
    .fpu_run    (fpu_run),
    .fpu_running(fpu_running),
    .fpu_op     (fpu_op),
    .fpu_in0    (fpu_in0),
    .fpu_in1    (fpu_in1),
    .fpu_done   (fpu_done),
    .fpu_out0   (fpu_out0),
    .fpu_ovf    (fpu_ovf),
    .fpu_unf    (fpu_unf),
    .fpu_dbz    (fpu_dbz)
  );

  // ---------------------------------------------------------------------------
  // Behavioural fpu
  // ---------------------------------------------------------------------------
  int         lat       = 5;
  bit         hold_done = 1'b0;
  logic [2:0] flag_mode = 3'b000;   // {dbz, unf, ovf} raised with done
  int         mcnt      = 0;
  logic       model_fire;

  assign model_fire = fpu_run && !hold_done && (mcnt == lat - 1);

  always @(posedge clk) begin
    mcnt     <= fpu_run ? mcnt + 1 : 0;
    fpu_done <= model_fire;
    fpu_dbz  <= model_fire & flag_mode[2];
    fpu_unf  <= model_fire & flag_mode[1];
    fpu_ovf  <= model_fire & flag_mode[0];
    fpu_out0 <= fpu_done ? (fpu_in0 + fpu_in1) : 32'hDEAD_BEEF;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          hold;
    logic [2:0]  fl;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    int          exp_lat;    // accept edge to res_valid, in clock edges
    int          exp_run;    // cycles with fpu_run high
    int          exp_capt;   // cycles with fpu_running high and fpu_run low
    int          stall;      // cycles res_ready is held low once the result is up
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] exp_cnt;

  // One complete operation: accept, wait, check result, optional stall, consume.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int runs;
    int capt;
    lat       = v.lat;
    hold_done = v.hold;
    flag_mode = v.fl;
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    tick();
    cmd_valid = 1'b0;
    cmd_a     = 32'h5555_5555;
    cmd_b     = 32'hAAAA_AAAA;
    check({tag, " run_up"}, 32'(fpu_run), 32'd1);
    check({tag, " fpu_op"}, 32'(fpu_op), 32'(v.op));
    check({tag, " fpu_in1"}, fpu_in1, v.b);
    cyc  = 0;
    runs = 0;
    capt = 0;
    while (!res_valid && cyc < 50) begin
      if (fpu_run) runs++;
      if (fpu_running && !fpu_run) capt++;
      tick();
      cyc++;
    end
    $display("op %s: op=%0d a=0x%0h b=0x%0h -> data=0x%0h flags=%b lat=%0d run=%0d",
             tag, v.op, v.a, v.b, res_data, res_flags, cyc, runs);
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
    check({tag, " run_cycles"}, 32'(runs), 32'(v.exp_run));
    check({tag, " capt_cycles"}, 32'(capt), 32'(v.exp_capt));
    check({tag, " res_data"}, res_data, v.exp_data);
    check({tag, " res_flags"}, 32'(res_flags), 32'(v.exp_flags));
    check({tag, " in0_stable"}, fpu_in0, v.a);
    check({tag, " ops_cnt_pre"}, 32'(ops_cnt), 32'(exp_cnt));
    for (int i = 0; i < v.stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = ~v.op;
      tick();
      check({tag, " stall_valid"}, 32'(res_valid), 32'd1);
      check({tag, " stall_data"}, res_data, v.exp_data);
      check({tag, " stall_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, " stall_op"}, 32'(fpu_op), 32'(v.op));
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + 4'd1;
    check({tag, " res_done"}, 32'(res_valid), 32'd0);
    check({tag, " ops_cnt"}, 32'(ops_cnt), 32'(exp_cnt));
    check({tag, " ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check({tag, " res_data"}, res_data, 32'd0);
    check({tag, " res_flags"}, 32'(res_flags), 32'd0);
    check({tag, " ops_cnt"}, 32'(ops_cnt), 32'd0);
    check({tag, " fpu_run"}, 32'(fpu_run), 32'd0);
    check({tag, " fpu_running"}, 32'(fpu_running), 32'd0);
    check({tag, " fpu_op"}, 32'(fpu_op), 32'd0);
    check({tag, " fpu_in0"}, fpu_in0, 32'd0);
    check({tag, " fpu_in1"}, fpu_in1, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vec_t v;

    //          op     a             b             lat hold fl      data          flags    lat run capt stall
    vecs[0] = '{2'b00, 32'd3,        32'd4,        5,  0, 3'b000, 32'd7,        4'b0000, 7,  6,  1,  10};
    vecs[1] = '{2'b01, 32'd10,       32'd20,       5,  1, 3'b000, 32'd0,        4'b1000, 8,  8,  0,  0};
    vecs[2] = '{2'b10, 32'd100,      32'd0,        3,  0, 3'b100, 32'd100,      4'b0100, 5,  4,  1,  0};
    vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'd1,       1,  0, 3'b001, 32'd0,        4'b0001, 3,  2,  1,  0};
    vecs[4] = '{2'b00, 32'h0000_1000, 32'h0000_0234, 7, 0, 3'b010, 32'h0000_1234, 4'b0010, 9, 8,  1,  0};
    vecs[5] = '{2'b00, 32'd6,        32'd5,        6,  0, 3'b011, 32'd11,       4'b0011, 8,  7,  1,  0};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    exp_cnt   = 4'd0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_reset res_valid", 32'(res_valid), 32'd0);

    // Table of operations, issued back to back
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while waiting on the fpu
    lat       = 5;
    hold_done = 1'b0;
    flag_mode = 3'b000;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 32'd42;
    cmd_b     = 32'd58;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("midop fpu_run", 32'(fpu_run), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    $display("reset mid-op: run=%0b running=%0b cnt=%0d", fpu_run, fpu_running, ops_cnt);
    exp_cnt = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    v       = vecs[0];
    v.stall = 0;
    run_vec(v, "after_rst");

    // Counter wrap: 14 more quick ops reach 15, the next one wraps to 0
    for (int i = 0; i < 14; i++) begin
      v = '{2'b00, 32'(i), 32'd1, 1, 0, 3'b000, 32'(i + 1), 4'b0000, 3, 2, 1, 0};
      run_vec(v, $sformatf("fill%0d", i));
    end
    check("cnt_at_15", 32'(ops_cnt), 32'd15);
    run_vec(vecs[4], "wrap");
    check("cnt_wrapped", 32'(ops_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
